// File: rtl/break_arbiter_pkg.sv
// break_arbiter_pkg: shared widths, state encoding and index helpers for the data-break arbiter
package break_arbiter_pkg;
   localparam int ADDR_W  = 15;
   localparam int WORD_W  = 12;
   localparam int MAX_REQ = 4;
   typedef enum logic [2:0] {BA_IDLE, BA_REQ, BA_XFER, BA_DONE, BA_WAIT} ba_state_t;
   function automatic logic [1:0] oh_idx(input logic [MAX_REQ-1:0] v);
      return v[3] ? 2'd3 : v[2] ? 2'd2 : v[1] ? 2'd1 : 2'd0;
   endfunction
   function automatic logic [1:0] rr_next(input logic [1:0] idx, input int n);
      return (int'(idx) + 1 >= n) ? 2'd0 : idx + 2'd1;
   endfunction
endpackage

// File: rtl/break_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or after ptr wins
module rr_pick #(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [1:0]      ptr,
   output logic [NREQ-1:0] gnt
);
   logic found;
   always_comb begin
      gnt = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++)
         for (int i = 0; i < NREQ; i++)
            if (!found && req[i] && i == (int'(ptr) + k) % NREQ) begin
               gnt[i] = 1'b1;
               found = 1'b1;
            end
   end
endmodule

// File: rtl/break_arbiter.sv
// break_arbiter: round-robin owner of the single-cycle data-break memory path
module break_arbiter
   import break_arbiter_pkg::*;
#(
   parameter int NREQ      = 2,
   parameter int BREAK_LEN = 3
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     clear,
   input  logic [NREQ-1:0]          brk_req,
   input  logic [NREQ-1:0]          brk_to_mem,
   input  logic [0:ADDR_W*NREQ-1]   brk_addr,
   input  logic [0:WORD_W*NREQ-1]   brk_wdata,
   input  logic                     break_in_prog,
   input  logic [0:WORD_W-1]        mem2disk,
   output logic                     data_break,
   output logic                     to_disk,
   output logic [0:ADDR_W-1]        dmaAddr,
   output logic [0:WORD_W-1]        disk2mem,
   output logic [NREQ-1:0]          brk_gnt,
   output logic [NREQ-1:0]          brk_done,
   output logic [0:WORD_W-1]        brk_rdata
);
   localparam int CNT_W = $clog2(BREAK_LEN + 1);
   ba_state_t state, nxt;
   logic [CNT_W-1:0] cnt;
   logic [1:0] rr;
   logic [NREQ-1:0] pick;
   logic [0:ADDR_W-1] sel_addr;
   logic [0:WORD_W-1] sel_wdata;
   logic sel_to_mem, own_req, busy, busy_nxt;
   rr_pick #(.NREQ(NREQ)) u_pick (.req(brk_req), .ptr(rr), .gnt(pick));
   assign own_req  = |(brk_req & brk_gnt);
   assign brk_done = (state == BA_DONE) ? brk_gnt : '0;
   assign busy     = state == BA_REQ || state == BA_XFER;
   assign busy_nxt = nxt == BA_REQ || nxt == BA_XFER;
   always_comb begin
      sel_addr = '0;
      sel_wdata = '0;
      sel_to_mem = 1'b0;
      for (int i = 0; i < NREQ; i++)
         if (pick[i]) begin
            sel_addr = brk_addr[ADDR_W*i +: ADDR_W];
            sel_wdata = brk_wdata[WORD_W*i +: WORD_W];
            sel_to_mem = brk_to_mem[i];
         end
   end
   // once memory has acknowledged, the cycle runs to completion regardless of clear or drop
   always_comb begin
      nxt = state;
      case (state)
         BA_IDLE: nxt = (|brk_req && !break_in_prog) ? BA_REQ : BA_IDLE;
         BA_REQ:  nxt = break_in_prog ? BA_XFER : (clear || !own_req) ? BA_IDLE : BA_REQ;
         BA_XFER: nxt = (cnt == '0) ? BA_DONE : BA_XFER;
         BA_DONE: nxt = BA_WAIT;
         BA_WAIT: nxt = break_in_prog ? BA_WAIT : BA_IDLE;
         default: nxt = BA_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) state <= BA_IDLE;
      else state <= nxt;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         data_break <= 1'b0;
         to_disk <= 1'b0;
         dmaAddr <= '0;
         disk2mem <= '0;
         brk_gnt <= '0;
         brk_rdata <= '0;
         cnt <= '0;
         rr <= '0;
      end else begin
         data_break <= busy && busy_nxt;
         if (state == BA_IDLE && nxt == BA_REQ) begin
            brk_gnt <= pick;
            dmaAddr <= sel_addr;
            disk2mem <= sel_wdata;
            to_disk <= ~sel_to_mem;
         end
         if ((state == BA_REQ || state == BA_WAIT) && nxt == BA_IDLE) brk_gnt <= '0;
         if (state == BA_REQ && nxt == BA_XFER) cnt <= CNT_W'(BREAK_LEN - 1);
         else if (state == BA_XFER && cnt != '0) cnt <= cnt - CNT_W'(1);
         if (state == BA_XFER && cnt == '0 && to_disk) brk_rdata <= mem2disk;
         if (state == BA_DONE) rr <= rr_next(oh_idx(MAX_REQ'(brk_gnt)), NREQ);
      end
endmodule

// File: tb/tb_break_arbiter.sv
// tb_break_arbiter: vector table plus corner sequences, breaks checked against an expectation queue
module tb_break_arbiter;
   localparam int NREQ = 2;
   localparam int BREAK_LEN = 3;
   logic clk = 1'b0;
   logic resetn, clear, break_in_prog, data_break, to_disk;
   logic [NREQ-1:0] brk_req, brk_to_mem, brk_gnt, brk_done;
   logic [0:15*NREQ-1] brk_addr;
   logic [0:12*NREQ-1] brk_wdata;
   logic [0:11] mem2disk, disk2mem, brk_rdata;
   logic [0:14] dmaAddr;
   always #5 clk = ~clk;
   break_arbiter #(.NREQ(NREQ), .BREAK_LEN(BREAK_LEN)) dut (
      .clk(clk), .resetn(resetn), .clear(clear), .brk_req(brk_req), .brk_to_mem(brk_to_mem),
      .brk_addr(brk_addr), .brk_wdata(brk_wdata), .break_in_prog(break_in_prog), .mem2disk(mem2disk),
      .data_break(data_break), .to_disk(to_disk), .dmaAddr(dmaAddr), .disk2mem(disk2mem),
      .brk_gnt(brk_gnt), .brk_done(brk_done), .brk_rdata(brk_rdata)
   );
   typedef struct {
      logic [1:0]  done;
      logic [0:14] addr;
      logic [0:11] wdata;
      logic        to_disk;
      logic [0:11] rdata;
   } exp_t;
   typedef struct {
      int          idx;
      logic        to_mem;
      logic [0:14] addr;
      logic [0:11] wdata;
      logic        exp_to_disk;
      logic [1:0]  exp_done;
      logic [0:11] exp_rdata;
   } vec_t;
   exp_t q[$];
   vec_t vt[6];
   int checks = 0, failures = 0, k_bip = 0, n, m;
   int rep[NREQ];
   bit auto_bip = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0o required=%0o", name, act, exp);
      end
   endtask

   function automatic logic [0:11] mem_word(input logic [0:14] a);
      return a[3:14] ^ 12'o5252;
   endfunction

   // one clock: check outputs, release finished requesters, act as the memory state machine
   task automatic step();
      exp_t e;
      @(negedge clk);
      chk("gnt_onehot", 32'($onehot0(brk_gnt)), 32'd1);
      if (resetn && brk_done != '0) begin
         if (q.size() == 0) chk("done_unexpected", 32'(brk_done), 32'd0);
         else begin
            e = q.pop_front();
            chk("done", 32'(brk_done), 32'(e.done));
            chk("gnt_at_done", 32'(brk_gnt), 32'(e.done));
            chk("addr", 32'(dmaAddr), 32'(e.addr));
            chk("wdata", 32'(disk2mem), 32'(e.wdata));
            chk("to_disk", 32'(to_disk), 32'(e.to_disk));
            chk("rdata", 32'(brk_rdata), 32'(e.rdata));
         end
      end
      for (int i = 0; i < NREQ; i++)
         if (brk_done[i] && rep[i] > 0) begin
            rep[i]--;
            if (rep[i] == 0) brk_req[i] = 1'b0;
         end
      if (auto_bip) begin
         if (!break_in_prog && data_break) begin
            break_in_prog = 1'b1;
            k_bip = 0;
         end else if (break_in_prog) begin
            if (brk_done != '0) break_in_prog = 1'b0;
            else begin
               k_bip++;
               mem2disk = (k_bip == BREAK_LEN) ? mem_word(dmaAddr) : ~mem_word(dmaAddr);
            end
         end
      end
   endtask

   task automatic req_on(input int i, input logic tm, input logic [0:14] a, input logic [0:11] w, input int cnt);
      brk_to_mem[i] = tm;
      brk_addr[15*i +: 15] = a;
      brk_wdata[12*i +: 12] = w;
      rep[i] = cnt;
      brk_req[i] = 1'b1;
   endtask

   task automatic push(input logic [1:0] d, input logic [0:14] a, input logic [0:11] w, input logic td, input logic [0:11] r);
      exp_t e;
      e.done = d; e.addr = a; e.wdata = w; e.to_disk = td; e.rdata = r;
      q.push_back(e);
   endtask

   task automatic wait_db(output int cyc);
      cyc = 0;
      do begin step(); cyc++; end while (!data_break && cyc < 20);
   endtask

   task automatic drain(input string name);
      int c = 0;
      while (q.size() != 0 && c < 200) begin step(); c++; end
      chk(name, 32'(q.size()), 32'd0);
      repeat (4) step();
   endtask

   initial begin
      vt[0] = '{0, 1'b1, 15'o01234, 12'o7070, 1'b0, 2'b01, 12'o0000};
      vt[1] = '{1, 1'b0, 15'o01173, 12'o0000, 1'b1, 2'b10, 12'o4321};
      vt[2] = '{0, 1'b0, 15'o77777, 12'o1111, 1'b1, 2'b01, 12'o2525};
      vt[3] = '{1, 1'b1, 15'o00000, 12'o7777, 1'b0, 2'b10, 12'o2525};
      vt[4] = '{0, 1'b1, 15'o40000, 12'o0001, 1'b0, 2'b01, 12'o2525};
      vt[5] = '{1, 1'b0, 15'o00000, 12'o0000, 1'b1, 2'b10, 12'o5252};
      resetn = 1'b0; clear = 1'b0; break_in_prog = 1'b0; mem2disk = '0;
      brk_req = '0; brk_to_mem = '0; brk_addr = '0; brk_wdata = '0;
      for (int i = 0; i < NREQ; i++) rep[i] = 0;
      repeat (2) step();
      chk("rst_db", 32'(data_break), 32'd0);
      chk("rst_gnt", 32'(brk_gnt), 32'd0);
      chk("rst_done", 32'(brk_done), 32'd0);
      chk("rst_addr", 32'(dmaAddr), 32'd0);
      chk("rst_wdata", 32'(disk2mem), 32'd0);
      chk("rst_to_disk", 32'(to_disk), 32'd0);
      chk("rst_rdata", 32'(brk_rdata), 32'd0);
      // both requesters from reset: 0, 1, 0
      req_on(0, 1'b1, 15'o00100, 12'o1111, 2);
      req_on(1, 1'b1, 15'o00200, 12'o2222, 1);
      push(2'b01, 15'o00100, 12'o1111, 1'b0, 12'o0000);
      push(2'b10, 15'o00200, 12'o2222, 1'b0, 12'o0000);
      push(2'b01, 15'o00100, 12'o1111, 1'b0, 12'o0000);
      auto_bip = 1'b1;
      resetn = 1'b1;
      drain("rr_three");
      foreach (vt[j]) begin
         req_on(vt[j].idx, vt[j].to_mem, vt[j].addr, vt[j].wdata, 1);
         push(vt[j].exp_done, vt[j].addr, vt[j].wdata, vt[j].exp_to_disk, vt[j].exp_rdata);
         wait_db(n);
         chk("req_to_db", 32'(n), 32'd2);
         chk("db_addr", 32'(dmaAddr), 32'(vt[j].addr));
         chk("db_to_disk", 32'(to_disk), 32'(vt[j].exp_to_disk));
         m = 0;
         do begin step(); m++; end while (brk_done == '0 && m < 20);
         chk("bip_to_done", 32'(m), 32'(BREAK_LEN + 1));
         step();
         chk("done_width", 32'(brk_done), 32'd0);
         chk("rdata_hold", 32'(brk_rdata), 32'(vt[j].exp_rdata));
         drain("vec_drain");
      end
      // withdraw in REQ leaves rr at 0
      auto_bip = 1'b0;
      req_on(0, 1'b1, 15'o03333, 12'o3333, 1);
      wait_db(n);
      chk("wd_db_rise", 32'(n), 32'd2);
      brk_req[0] = 1'b0;
      step();
      chk("withdraw_db", 32'(data_break), 32'd0);
      repeat (4) step();
      chk("withdraw_gnt", 32'(brk_gnt), 32'd0);
      auto_bip = 1'b1;
      req_on(0, 1'b1, 15'o04444, 12'o4444, 1);
      req_on(1, 1'b1, 15'o05555, 12'o5555, 1);
      push(2'b01, 15'o04444, 12'o4444, 1'b0, 12'o5252);
      push(2'b10, 15'o05555, 12'o5555, 1'b0, 12'o5252);
      drain("wd_rr");
      // clear and request drop during XFER are ignored
      req_on(0, 1'b1, 15'o06060, 12'o0606, 1);
      push(2'b01, 15'o06060, 12'o0606, 1'b0, 12'o5252);
      n = 0;
      while (!break_in_prog && n < 20) begin step(); n++; end
      step();
      clear = 1'b1;
      brk_req[0] = 1'b0;
      step();
      clear = 1'b0;
      drain("clr_xfer");
      // clear in REQ aborts without done
      auto_bip = 1'b0;
      req_on(0, 1'b1, 15'o07070, 12'o7070, 1);
      wait_db(n);
      chk("clr_db_rise", 32'(n), 32'd2);
      clear = 1'b1;
      step();
      clear = 1'b0;
      brk_req[0] = 1'b0;
      chk("clr_req_db", 32'(data_break), 32'd0);
      repeat (4) step();
      chk("clr_req_gnt", 32'(brk_gnt), 32'd0);
      // async reset mid-XFER, then rr restarts at 0
      auto_bip = 1'b1;
      req_on(0, 1'b1, 15'o01111, 12'o1111, 1);
      req_on(1, 1'b1, 15'o02222, 12'o2222, 1);
      n = 0;
      while (!break_in_prog && n < 20) begin step(); n++; end
      chk("pre_rst_bip", 32'(break_in_prog), 32'd1);
      step();
      resetn = 1'b0;
      auto_bip = 1'b0;
      break_in_prog = 1'b0;
      #1;
      chk("arst_db", 32'(data_break), 32'd0);
      chk("arst_gnt", 32'(brk_gnt), 32'd0);
      chk("arst_done", 32'(brk_done), 32'd0);
      chk("arst_addr", 32'(dmaAddr), 32'd0);
      chk("arst_wdata", 32'(disk2mem), 32'd0);
      chk("arst_to_disk", 32'(to_disk), 32'd0);
      repeat (2) step();
      push(2'b01, 15'o01111, 12'o1111, 1'b0, 12'o0000);
      push(2'b10, 15'o02222, 12'o2222, 1'b0, 12'o0000);
      auto_bip = 1'b1;
      resetn = 1'b1;
      drain("post_reset");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
